// File: rtl/adder_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial adder: default width,
// nibble width and the controller state encoding.
package adder_nibble_seq_pkg;

    // Default operand width of the controller.
    localparam int DATA_W_DEF = 16;

    // Width of one carry-lookahead slice.
    localparam int NIB_W = 4;

    // Controller states.
    //   ST_IDLE : waiting for operands, o_ready=1
    //   ST_RUN  : one nibble added per clock
    //   ST_DONE : result presented, waiting for downstream
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Signed overflow of the MSB given the carry into and out of it.
    function automatic logic signed_ovf(input logic carry_in_msb,
                                        input logic carry_out_msb);
        return carry_in_msb ^ carry_out_msb;
    endfunction

endpackage : adder_nibble_seq_pkg

// File: rtl/adder_nibble_seq_lca_nibble_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// cout_bit[i] is the carry out of bit i, so cout_bit[3] is the slice
// carry-out and cout_bit[2] is the carry into the slice MSB.
module lca_nibble_slice
    import adder_nibble_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic [NIB_W-1:0] cout_bit
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;

    // Bitwise propagate (XOR, so it also serves the sum) and generate.
    assign p = a ^ b;
    assign g = a & b;

    // Flattened lookahead: every carry depends only on p, g and cin,
    // with no ripple through earlier carry outputs.
    always_comb begin
        cout_bit[0] = g[0] | (p[0] & cin);
        cout_bit[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        cout_bit[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);
        cout_bit[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & cin);
    end

    // Sum bit i = a ^ b ^ carry into bit i.
    assign sum = p ^ {cout_bit[NIB_W-2:0], cin};

endmodule : lca_nibble_slice

// File: rtl/adder_nibble_seq.sv
// Nibble-serial wide adder. One carry-lookahead slice is reused for
// NSLICE clocks, LSB nibble first, with valid/ready on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. o_ready depends only on state and i_ready (never on
// i_valid); o_valid stays high and o_sum/o_cout/o_ovf stay stable until
// the result is taken with i_ready=1.
module adder_nibble_seq
    import adder_nibble_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSLICE = DATA_W / NIB_W,
    parameter int CNT_W  = $clog2(NSLICE)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_cin,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_cout,
    output logic              o_ovf,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    logic [NIB_W-1:0]  slice_sum;
    logic [NIB_W-1:0]  slice_cout;
    logic              accept;

    // The single shared slice always works on the low nibbles.
    lca_nibble_slice u_slice (
        .a        (a_q[NIB_W-1:0]),
        .b        (b_q[NIB_W-1:0]),
        .cin      (carry_q),
        .sum      (slice_sum),
        .cout_bit (slice_cout)
    );

    // Lower slice carries are internal to the nibble and not needed here.
    logic unused_slice_carries;
    assign unused_slice_carries = ^slice_cout[NIB_W-3:0];

    // Ready when idle, or when the held result is being taken this cycle.
    assign o_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & i_ready);
    assign accept  = i_valid & o_ready;

    // Next-state and datapath update for the controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    carry_d = i_cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Sum nibble enters at the top; after NSLICE shifts the
                // first nibble has reached bits [3:0].
                res_d   = {slice_sum, res_q[DATA_W-1:NIB_W]};
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                carry_d = slice_cout[NIB_W-1];
                if (cnt_q == LAST_CNT) begin
                    sum_d   = {slice_sum, res_q[DATA_W-1:NIB_W]};
                    cout_d  = slice_cout[NIB_W-1];
                    ovf_d   = signed_ovf(slice_cout[NIB_W-2], slice_cout[NIB_W-1]);
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    if (accept) begin
                        // Back-to-back: the next operands load as the
                        // current result leaves.
                        a_d     = i_a;
                        b_d     = i_b;
                        carry_d = i_cin;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid = valid_q;
    assign o_sum   = sum_q;
    assign o_cout  = cout_q;
    assign o_ovf   = ovf_q;
    assign o_busy  = (state_q == ST_RUN);

endmodule : adder_nibble_seq

// File: tb/tb_adder_nibble_seq.sv
// Directed and randomised checks for the nibble-serial adder.
module tb_adder_nibble_seq;

    localparam int W = 16;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_cin;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_ovf;
    logic         o_busy;

    int n_checks = 0;
    int n_err    = 0;

    adder_nibble_seq #(.DATA_W(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf),
        .o_busy  (o_busy)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[11];

    // ---------------- driver tasks ----------------
    // Present operands from IDLE, wait for the result, check it, take it.
    task automatic apply_vec(input vec_t v, input string tag);
        int lat;
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_a = v.a; i_b = v.b; i_cin = v.cin; i_ready = 1'b0;
        @(negedge i_clk);
        check({tag, "_ready_idle"}, 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"},  32'(o_sum),  32'(v.sum));
        check({tag, "_cout"}, 32'(o_cout), 32'(v.cout));
        check({tag, "_ovf"},  32'(o_ovf),  32'(v.ovf));
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    endtask

    // ---------------- random scoreboard ----------------
    logic [W+1:0] exp_q[$];
    int           n_rand = 1000;
    int           n_recv;

    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic cin);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    task automatic rand_driver();
        logic [W-1:0] a, b;
        logic         c;
        logic         acc;
        int           guard;
        for (int t = 0; t < n_rand; t++) begin
            i_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge i_clk); #1;
            end
            a = W'($urandom); b = W'($urandom); c = 1'($urandom_range(0, 1));
            i_valid = 1'b1; i_a = a; i_b = b; i_cin = c;
            guard = 0;
            do begin
                @(negedge i_clk);
                acc = o_ready;
                @(posedge i_clk); #1;
                guard++;
            end while (!acc && guard < 200);
            if (!acc) begin
                check("rand_accept_timeout", 32'd0, 32'd1);
                break;
            end
            exp_q.push_back(ref_model(a, b, c));
        end
        i_valid = 1'b0;
    endtask

    task automatic rand_monitor();
        logic [W+1:0] exp;
        int           cycles;
        n_recv = 0;
        cycles = 0;
        while (n_recv < n_rand && cycles < 30000) begin
            @(posedge i_clk); #1;
            i_ready = ($urandom_range(0, 9) < 7);
            @(negedge i_clk);
            cycles++;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("rand_result", 32'({o_ovf, o_cout, o_sum}), 32'(exp));
                end
                n_recv++;
            end
        end
        check("rand_received", 32'(n_recv), 32'(n_rand));
    endtask

    // ---------------- main sequence ----------------
    logic [W-1:0] held_sum;
    int           lat;

    initial begin
        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0};
        vecs[2]  = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'h5555, 16'h5555, 1'b0, 16'hAAAA, 1'b0, 1'b1};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[9]  = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
        vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0;
        do_reset();

        // Reset state
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sum",   32'(o_sum),   32'd0);
        check("rst_cout",  32'(o_cout),  32'd0);
        check("rst_ovf",   32'(o_ovf),   32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);

        // Table-driven vectors
        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure in DONE, then back-to-back accept
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_a = 16'h1111; i_b = 16'h2222; i_cin = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (int k = 0; k < 16 && !o_valid; k++) begin
            @(posedge i_clk); #1;
        end
        held_sum = o_sum;
        check("bp_sum_first", 32'(o_sum), 32'h3333);
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            check("bp_valid_held", 32'(o_valid), 32'd1);
            check("bp_sum_held",   32'(o_sum),   32'(held_sum));
            check("bp_cout_held",  32'(o_cout),  32'd0);
            check("bp_ready_low",  32'(o_ready), 32'd0);
        end
        i_valid = 1'b1; i_a = 16'h0003; i_b = 16'h0004; i_cin = 1'b0;
        i_ready = 1'b1;
        #1;
        check("b2b_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_ready = 1'b0;
        check("b2b_valid_drop", 32'(o_valid), 32'd0);
        check("b2b_busy",       32'(o_busy),  32'd1);
        lat = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                lat = k;
                break;
            end
        end
        check("b2b_latency", 32'(lat),   32'd4);
        check("b2b_sum",     32'(o_sum), 32'h0007);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;

        // Asynchronous reset in the middle of RUN
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_a = 16'hFFFF; i_b = 16'h0001; i_cin = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk); #3;
        i_rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(o_busy),  32'd0);
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        check("arst_sum",   32'(o_sum),   32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (6) begin
            @(posedge i_clk); #1;
            check("arst_no_pulse", 32'(o_valid), 32'd0);
        end
        apply_vec('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0}, "post_rst");

        // Random traffic with random valid/ready gaps
        fork
            rand_driver();
            rand_monitor();
        join
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule : tb_adder_nibble_seq

// File: doc/adder_nibble_seq.md
Name: adder_nibble_seq

Overview:
Multi-cycle wide adder controller that time-multiplexes one 4-bit carry-lookahead slice to add two DATA_W-bit operands, one nibble per clock, LSB nibble first.
- Used in the modulator datapath where area matters more than throughput, e.g. wide accumulator updates that tolerate DATA_W/4 cycles of latency.
- Valid/ready handshake on both input and output sides.

Parameters:
DATA_W, 16, operand width; must be a multiple of 4 and >= 8.
NSLICE, DATA_W/4, derived nibble count; not to be overridden.
CNT_W, $clog2(NSLICE), slice counter width.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst_n  in  1  reset; asynchronous assert, active-low.
i_valid  in  1  input operands valid.
o_ready  out  1  block can accept operands this cycle.
i_a  in  DATA_W  operand A.
i_b  in  DATA_W  operand B.
i_cin  in  1  carry-in to the LSB nibble.
o_valid  out  1  result valid.
i_ready  in  1  downstream accepts the result.
o_sum  out  DATA_W  (A + B + cin) mod 2^DATA_W.
o_cout  out  1  carry out of bit DATA_W-1.
o_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
o_busy  out  1  high in RUN.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset values: state=IDLE, counter=0, carry=0, operand and result regs=0. Output reset values: o_valid=0, o_sum=0, o_cout=0, o_ovf=0, o_busy=0. o_ready=1 as soon as i_rst_n is deasserted.
- o_ready = (state==IDLE) | (state==DONE & i_ready). Combinational from state and i_ready only; it never depends on i_valid.
- Accept happens when i_valid & o_ready. On accept:
  - latch i_a and i_b into shift registers, carry <= i_cin, counter <= 0;
  - state <= RUN.
  - Inputs are ignored in all other cycles.
- Each RUN cycle:
  - Slice adds the low nibbles of the A/B shift regs plus carry.
  - The sum nibble shifts into the result register from the MSB side, so after NSLICE shifts nibble 0 is at [3:0].
  - A/B regs shift right by 4; carry <= slice carry-out bit 3.
  - On the last slice (counter==NSLICE-1): capture slice carry bit 2 as the MSB carry-in, set o_ovf = bit2 ^ bit3 and o_cout = bit3, then state <= DONE.
  - Otherwise counter increments.
- Latency: accept at edge T, o_valid high after edge T+NSLICE (4 cycles for DATA_W=16).
- DONE:
  - o_valid=1; o_sum, o_cout and o_ovf are held stable while i_ready=0.
  - i_ready=1 without accept -> IDLE, o_valid=0.
  - i_ready=1 with i_valid -> new accept in the same cycle, state <= RUN, o_valid drops (back-to-back, no bubble).
- o_sum, o_cout and o_ovf hold their last value in IDLE and RUN, and are only meaningful while o_valid=1.
- Arithmetic: the slice sum must be a ^ b ^ c. Use propagate p = a ^ b for the sum; an OR-based propagate is illegal for the sum path. Generate g = a & b; lookahead carries c[i+1] = g[i] | p[i]&c[i].
- Async reset mid-RUN or mid-DONE: immediate return to IDLE with reset values; the partial result is discarded and no o_valid pulse is produced.
- i_ready or i_valid toggling during RUN has no effect.

Decomposition:
- Shared package: DATA_W default, the state enum (IDLE/RUN/DONE encoding, 2 bits) and the nibble width constant 4.
- Sub-module lca_nibble_slice: purely combinational 4-bit carry-lookahead.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], cout_bit[3:0], where cout_bit[i] is the carry out of bit i.
- The controller instantiates exactly one slice.

Test Plan:
- 0x00FF + 0x0001, cin=0 -> o_sum=0x0100, o_cout=0, o_ovf=0; o_valid first high 4 cycles after the accept edge.
- 0x1111 + 0x1111, cin=0 -> 0x2222. Also 0xAAAA + 0x5555, cin=1 -> o_sum=0x0000, o_cout=1. These catch OR-propagate sum errors and carry chaining across nibbles.
- 0x7FFF + 0x0001 -> 0x8000, o_cout=0, o_ovf=1. 0xFFFF + 0x0001 -> 0x0000, o_cout=1, o_ovf=0.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid, o_sum and o_cout stable, o_ready=0. Then assert i_ready with i_valid=1 (0x0003 + 0x0004) -> accepted that cycle, result 0x0007 exactly 4 cycles later.
- Drop i_rst_n after 2 RUN cycles -> o_busy=0, o_valid=0, o_ready=1 without waiting for a clock edge. After release, 0x1234 + 0x4321 -> 0x5555 with correct latency.
- Random 1000 operand pairs with random i_valid/i_ready gaps -> every result matches the reference model (A+B+cin), no lost or duplicated transactions.
